des_key_schedule: RTL

- Sequential DES key-schedule engine that sits directly upstream of the PC2 permutation stage.
- Loads a 64-bit key, applies PC1 (parity bits dropped), and holds the 28-bit C and D halves in registers.
- Steps the halves through the 16 DES rotation rounds on request, presenting the 56-bit CD word each round for PC2 to compress into the round subkey.
- Supports encrypt order (left rotations, K1..K16) and decrypt order (right rotations, K16..K1).

---
 rtl/des_key_schedule_pkg.sv | 34 +++
 rtl/des_key_schedule_pc1.sv | 16 +
 rtl/des_key_schedule.sv | 106 ++++++++++
 3 files changed

// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule constants, tables, types and rotate helpers.
package des_ks_pkg;

    localparam int unsigned HALF_W = 28;
    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 2 * HALF_W;

    typedef logic [0:HALF_W-1] half_t;

    typedef enum logic {
        ST_IDLE,
        ST_ROUND
    } state_t;

    // Entry k holds the rotation amount of round k+1.
    localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // DES-numbered (1-based) source bit for each PC1 output bit.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    function automatic half_t rotl(input half_t x, input int unsigned n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic half_t rotr(input half_t x, input int unsigned n);
        return (x >> n) | (x << (HALF_W - n));
    endfunction

endpackage

// File: rtl/des_key_schedule_pc1.sv
// Combinational DES PC1: 64-bit key to 56-bit C||D, parity bits dropped.
module des_pc1
    import des_ks_pkg::*;
(
    input  logic [0:63] key_i,
    output logic [0:55] cd_o
);

    always_comb begin
        cd_o = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            cd_o[6'(i)] = key_i[6'(PC1_TAB[6'(i)] - 1)];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC1 on load, then 16 C/D rotation rounds.
// Optional internal PC2 subkey output enabled by defining DES_KS_SUBKEY_OUT_EN.
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned HALF_W     = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [0:63] key_in,
    input  logic        decrypt,
    input  logic        round_adv,
    output logic [0:55] cd_out,
    output logic [3:0]  round_idx,
    output logic        cd_valid,
    output logic        last_round
`ifdef DES_KS_SUBKEY_OUT_EN
    ,
    output logic [0:47] subkey_out,
    output logic        subkey_valid
`endif
);
    import des_ks_pkg::*;

    state_t      state_q;
    logic [0:55] cd_q;
    logic [3:0]  round_q;
    logic        mode_q;

    logic [0:55] pc1_cd;
    logic [0:55] cd_ld_d;
    logic [0:55] cd_adv_d;
    logic [3:0]  sh_idx_d;
    half_t       c_cur, d_cur, c_ld, d_ld;

    des_pc1 u_pc1 (
        .key_i (key_in),
        .cd_o  (pc1_cd)
    );

    always_comb begin
        c_cur = cd_q[0:HALF_W-1];
        d_cur = cd_q[HALF_W:2*HALF_W-1];
        c_ld  = pc1_cd[0:HALF_W-1];
        d_ld  = pc1_cd[HALF_W:2*HALF_W-1];
        // Decrypt advancing from round r uses SHIFTS[17-r], i.e. table index 16-r == -r mod 16.
        sh_idx_d = mode_q ? (4'd0 - round_q) : round_q;
        if (mode_q) begin
            cd_adv_d = {rotr(c_cur, SHIFTS[sh_idx_d]), rotr(d_cur, SHIFTS[sh_idx_d])};
        end else begin
            cd_adv_d = {rotl(c_cur, SHIFTS[sh_idx_d]), rotl(d_cur, SHIFTS[sh_idx_d])};
        end
        if (decrypt) begin
            cd_ld_d = pc1_cd;
        end else begin
            cd_ld_d = {rotl(c_ld, SHIFTS[0]), rotl(d_ld, SHIFTS[0])};
        end
    end

    // Round 16 wraps the 4-bit counter to 0; state distinguishes it from idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else if (key_load) begin
            state_q <= ST_ROUND;
            cd_q    <= cd_ld_d;
            round_q <= 4'd1;
            mode_q  <= decrypt;
        end else if (state_q == ST_ROUND && round_adv) begin
            if (round_q == 4'(NUM_ROUNDS)) begin
                state_q <= ST_IDLE;
                round_q <= '0;
            end else begin
                cd_q    <= cd_adv_d;
                round_q <= round_q + 4'd1;
            end
        end
    end

    assign cd_out     = cd_q;
    assign round_idx  = round_q;
    assign cd_valid   = (state_q == ST_ROUND);
    assign last_round = cd_valid && (round_q == 4'(NUM_ROUNDS));

`ifdef DES_KS_SUBKEY_OUT_EN
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    always_comb begin
        subkey_out = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            subkey_out[6'(i)] = cd_q[6'(PC2_TAB[6'(i)] - 1)];
        end
    end

    assign subkey_valid = cd_valid;
`endif

endmodule
